// File: rtl/vanilla_remote_load_wb.sv
// Remote load response buffer for the vanilla core: queues raw network load
// responses, formats byte/halfword loads and routes them to int or FP writeback.
module vanilla_remote_load_wb #(
  parameter int els_p          = 2,
  parameter int reg_id_width_p = 5
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic                          v_i,
  // {float_wb, reg_id, is_unsigned_op, is_byte_op, is_hex_op, part_sel[1:0], data[31:0]}
  input  logic [reg_id_width_p+37:0]    resp_i,
  output logic                          ready_o,
  output logic                          int_v_o,
  output logic [reg_id_width_p-1:0]     int_rd_o,
  output logic [31:0]                   int_data_o,
  input  logic                          int_yumi_i,
  output logic                          float_v_o,
  output logic [reg_id_width_p-1:0]     float_rd_o,
  output logic [31:0]                   float_data_o,
  input  logic                          float_yumi_i,
  output logic [$clog2(els_p+1)-1:0]    count_o
);

  localparam int ptr_width_lp   = $clog2(els_p);
  localparam int count_width_lp = $clog2(els_p+1);
  localparam int resp_width_lp  = reg_id_width_p + 38;

  // Handshakes: a response transfers in on any cycle with v_i & ready_o.
  // A writeback valid holds with stable rd/data until its yumi; yumi is only
  // legal while the matching valid is high and pops the head on that cycle.

  logic [resp_width_lp-1:0]  mem_r [els_p];
  logic [ptr_width_lp-1:0]   wptr_r, rptr_r;
  logic [count_width_lp-1:0] count_r;

  logic [resp_width_lp-1:0]  head;
  logic                      head_float_wb;
  logic [reg_id_width_p-1:0] head_reg_id;
  logic                      head_unsigned;
  logic                      head_byte;
  logic                      head_hex;
  logic [1:0]                head_part_sel;
  logic [31:0]               head_data;
  logic [7:0]                byte_sel;
  logic [15:0]               hex_sel;
  logic [31:0]               fmt_data;

  logic has_head, float_sel, int_sel, discard;
  logic enq, deq;

  assign head          = mem_r[rptr_r];
  assign head_float_wb = head[resp_width_lp-1];
  assign head_reg_id   = head[37 +: reg_id_width_p];
  assign head_unsigned = head[36];
  assign head_byte     = head[35];
  assign head_hex      = head[34];
  assign head_part_sel = head[33:32];
  assign head_data     = head[31:0];

  assign byte_sel = head_data[{head_part_sel, 3'b000} +: 8];
  assign hex_sel  = head_data[{head_part_sel[1], 4'b0000} +: 16];

  always_comb begin
    fmt_data = head_data;
    if (head_byte)
      fmt_data = {{24{~head_unsigned & byte_sel[7]}}, byte_sel};
    else if (head_hex)
      fmt_data = {{16{~head_unsigned & hex_sel[15]}}, hex_sel};
  end

  // Loads to x0 have no architectural effect, so they retire silently.
  assign has_head  = (count_r != '0);
  assign float_sel = has_head & head_float_wb;
  assign int_sel   = has_head & ~head_float_wb & (head_reg_id != '0);
  assign discard   = has_head & ~head_float_wb & (head_reg_id == '0);

  assign int_v_o      = int_sel;
  assign int_rd_o     = int_sel ? head_reg_id : '0;
  assign int_data_o   = int_sel ? fmt_data : '0;
  assign float_v_o    = float_sel;
  assign float_rd_o   = float_sel ? head_reg_id : '0;
  assign float_data_o = float_sel ? head_data : '0;

  assign ready_o = (count_r < count_width_lp'(els_p));
  assign count_o = count_r;

  assign enq = v_i & ready_o;
  assign deq = (int_yumi_i & int_sel) | (float_yumi_i & float_sel) | discard;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (enq) wptr_r <= wptr_r + ptr_width_lp'(1);
      if (deq) rptr_r <= rptr_r + ptr_width_lp'(1);
      count_r <= count_r + count_width_lp'(enq) - count_width_lp'(deq);
    end
  end

  // Storage needs no reset; entries are only observed while counted.
  always_ff @(posedge clk_i) begin
    if (enq) mem_r[wptr_r] <= resp_i;
  end

  a_int_yumi_needs_valid: assert property (
    @(posedge clk_i) disable iff (!reset_n_i) int_yumi_i |-> int_v_o);
  a_float_yumi_needs_valid: assert property (
    @(posedge clk_i) disable iff (!reset_n_i) float_yumi_i |-> float_v_o);
  a_one_hot_valid: assert property (
    @(posedge clk_i) disable iff (!reset_n_i) !(int_v_o && float_v_o));

endmodule

// File: tb/tb_vanilla_remote_load_wb.sv
// Directed bench for vanilla_remote_load_wb: formatting, routing, backpressure,
// x0 discard, simultaneous push/pop and asynchronous mid-operation reset.
module tb_vanilla_remote_load_wb;

  logic        clk_i;
  logic        reset_n_i;
  logic        v_i;
  logic [42:0] resp_i;
  logic        ready_o;
  logic        int_v_o;
  logic [4:0]  int_rd_o;
  logic [31:0] int_data_o;
  logic        int_yumi_i;
  logic        float_v_o;
  logic [4:0]  float_rd_o;
  logic [31:0] float_data_o;
  logic        float_yumi_i;
  logic [1:0]  count_o;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_data;

  vanilla_remote_load_wb #(.els_p(2), .reg_id_width_p(5)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .v_i(v_i), .resp_i(resp_i),
    .ready_o(ready_o), .int_v_o(int_v_o), .int_rd_o(int_rd_o),
    .int_data_o(int_data_o), .int_yumi_i(int_yumi_i), .float_v_o(float_v_o),
    .float_rd_o(float_rd_o), .float_data_o(float_data_o),
    .float_yumi_i(float_yumi_i), .count_o(count_o)
  );

  // clock / reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [42:0] mk(input logic fw, input logic [4:0] rid,
                                     input logic uns, input logic byt, input logic hex,
                                     input logic [1:0] ps, input logic [31:0] d);
    return {fw, rid, uns, byt, hex, ps, d};
  endfunction

  // formatting vectors: {uns, byte, hex, part_sel} and hand-computed results
  logic [4:0]  fmt_ctl [7] = '{5'b01011, 5'b11010, 5'b00110, 5'b10100,
                               5'b01001, 5'b01100, 5'b00000};
  logic [31:0] fmt_exp [7] = '{32'hFFFFFF80, 32'h000000FF, 32'hFFFF80FF, 32'h00007F01,
                               32'h0000007F, 32'h00000001, 32'h80FF7F01};

  initial begin
    reset_n_i = 1'b1; v_i = 1'b0; resp_i = '0; int_yumi_i = 1'b0; float_yumi_i = 1'b0;
    #1 reset_n_i = 1'b0;
    #2;
    check_eq("rst_ready", 32'(ready_o), 32'd1);
    check_eq("rst_count", 32'(count_o), 32'd0);
    check_eq("rst_int_v", 32'(int_v_o), 32'd0);
    check_eq("rst_float_v", 32'(float_v_o), 32'd0);
    check_eq("rst_int_data", int_data_o, 32'd0);
    repeat (2) @(posedge clk_i);
    #3 reset_n_i = 1'b1;
    tick();

    // byte/hex extraction, one push and one yumi per cycle
    for (int i = 0; i <= 7; i++) begin
      if (i > 0) begin
        check_eq("fmt_int_v", 32'(int_v_o), 32'd1);
        check_eq("fmt_int_rd", 32'(int_rd_o), 32'd3);
        check_eq($sformatf("fmt_data_%0d", i-1), int_data_o, fmt_exp[i-1]);
        check_eq("fmt_ready", 32'(ready_o), 32'd1);
      end
      int_yumi_i = (i > 0);
      v_i = (i < 7);
      if (i < 7)
        resp_i = mk(1'b0, 5'd3, fmt_ctl[i][4], fmt_ctl[i][3], fmt_ctl[i][2],
                    fmt_ctl[i][1:0], 32'h80FF7F01);
      tick();
    end
    int_yumi_i = 1'b0; v_i = 1'b0;
    check_eq("fmt_drained", 32'(count_o), 32'd0);

    // float routing ignores byte/unsigned bits
    v_i = 1'b1; resp_i = mk(1'b1, 5'd7, 1'b0, 1'b1, 1'b0, 2'd1, 32'h3F800000);
    tick();
    v_i = 1'b0;
    check_eq("flt_v", 32'(float_v_o), 32'd1);
    check_eq("flt_rd", 32'(float_rd_o), 32'd7);
    check_eq("flt_data", float_data_o, 32'h3F800000);
    check_eq("flt_int_v", 32'(int_v_o), 32'd0);
    check_eq("flt_int_rd", 32'(int_rd_o), 32'd0);
    float_yumi_i = 1'b1;
    tick();
    float_yumi_i = 1'b0;
    check_eq("flt_done_v", 32'(float_v_o), 32'd0);
    check_eq("flt_done_cnt", 32'(count_o), 32'd0);

    // full and backpressure
    v_i = 1'b1; resp_i = mk(1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h11111111);
    exp_q.push_back(32'h11111111);
    tick();
    check_eq("full_cnt1", 32'(count_o), 32'd1);
    check_eq("full_rdy1", 32'(ready_o), 32'd1);
    resp_i = mk(1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 2'd0, 32'h22222222);
    exp_q.push_back(32'h22222222);
    tick();
    check_eq("full_cnt2", 32'(count_o), 32'd2);
    check_eq("full_rdy2", 32'(ready_o), 32'd0);
    resp_i = mk(1'b0, 5'd4, 1'b0, 1'b0, 1'b0, 2'd0, 32'h33333333);
    tick();
    v_i = 1'b0;
    check_eq("full_cnt3", 32'(count_o), 32'd2);
    check_eq("full_rdy3", 32'(ready_o), 32'd0);
    check_eq("full_head_rd", 32'(int_rd_o), 32'd1);
    exp_data = exp_q.pop_front();
    check_eq("full_head_a", int_data_o, exp_data);
    int_yumi_i = 1'b1;
    tick();
    int_yumi_i = 1'b0;
    check_eq("full_rdy_back", 32'(ready_o), 32'd1);
    check_eq("full_cnt_back", 32'(count_o), 32'd1);
    check_eq("full_head_rd_b", 32'(int_rd_o), 32'd2);
    exp_data = exp_q.pop_front();
    check_eq("full_head_b", int_data_o, exp_data);
    int_yumi_i = 1'b1;
    tick();
    int_yumi_i = 1'b0;
    check_eq("full_empty", 32'(count_o), 32'd0);
    check_eq("full_no_c", 32'(int_v_o), 32'd0);

    // x0 discard
    v_i = 1'b1; resp_i = mk(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 32'hDEADBEEF);
    tick();
    check_eq("x0_int_v", 32'(int_v_o), 32'd0);
    check_eq("x0_float_v", 32'(float_v_o), 32'd0);
    check_eq("x0_cnt", 32'(count_o), 32'd1);
    resp_i = mk(1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 2'd0, 32'h00000055);
    tick();
    v_i = 1'b0;
    check_eq("x0_next_v", 32'(int_v_o), 32'd1);
    check_eq("x0_next_rd", 32'(int_rd_o), 32'd5);
    check_eq("x0_next_data", int_data_o, 32'h00000055);
    check_eq("x0_next_cnt", 32'(count_o), 32'd1);
    int_yumi_i = 1'b1;
    tick();
    int_yumi_i = 1'b0;
    check_eq("x0_empty", 32'(count_o), 32'd0);

    // simultaneous push/pop with pointer wrap
    v_i = 1'b1; resp_i = mk(1'b0, 5'd10, 1'b0, 1'b0, 1'b0, 2'd0, 32'hA0000000);
    exp_q.push_back(32'hA0000000);
    tick();
    for (int i = 0; i < 8; i++) begin
      check_eq("pp_cnt", 32'(count_o), 32'd1);
      check_eq("pp_v", 32'(int_v_o), 32'd1);
      check_eq($sformatf("pp_rd_%0d", i), 32'(int_rd_o), 32'(10 + i));
      exp_data = exp_q.pop_front();
      check_eq($sformatf("pp_data_%0d", i), int_data_o, exp_data);
      int_yumi_i = 1'b1;
      resp_i = mk(1'b0, 5'(11 + i), 1'b0, 1'b0, 1'b0, 2'd0, 32'hA0000001 + 32'(i));
      exp_q.push_back(32'hA0000001 + 32'(i));
      tick();
    end
    v_i = 1'b0;
    check_eq("pp_last_rd", 32'(int_rd_o), 32'd18);
    exp_data = exp_q.pop_front();
    check_eq("pp_last_data", int_data_o, exp_data);
    tick();
    int_yumi_i = 1'b0;
    check_eq("pp_empty", 32'(count_o), 32'd0);

    // asynchronous reset with two entries buffered
    v_i = 1'b1; resp_i = mk(1'b0, 5'd9, 1'b0, 1'b0, 1'b0, 2'd0, 32'h99999999);
    tick();
    resp_i = mk(1'b1, 5'd10, 1'b0, 1'b0, 1'b0, 2'd0, 32'hAAAAAAAA);
    tick();
    v_i = 1'b0;
    check_eq("mr_cnt_before", 32'(count_o), 32'd2);
    #2 reset_n_i = 1'b0;
    #1;
    check_eq("mr_int_v", 32'(int_v_o), 32'd0);
    check_eq("mr_int_rd", 32'(int_rd_o), 32'd0);
    check_eq("mr_int_data", int_data_o, 32'd0);
    check_eq("mr_float_v", 32'(float_v_o), 32'd0);
    check_eq("mr_cnt", 32'(count_o), 32'd0);
    check_eq("mr_ready", 32'(ready_o), 32'd1);
    repeat (2) @(posedge clk_i);
    #3 reset_n_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("mr_stale_int", 32'(int_v_o), 32'd0);
      check_eq("mr_stale_float", 32'(float_v_o), 32'd0);
      check_eq("mr_stale_cnt", 32'(count_o), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vanilla_remote_load_wb.md
# vanilla_remote_load_wb

Buffers remote load responses returning from the manycore network and formats them for register writeback in the vanilla core. Sits between the network endpoint's load-response output (`remote_load_resp_s`) and the writeback arbiters of the integer and FP register files. Extracts bytes and halfwords using the response's `part_sel`, then sign- or zero-extends them. Routes each response to the integer or float writeback port and holds it until that arbiter accepts it.

## Interface
- `els_p`, default 2: FIFO depth; power of two, ≥2.
- `reg_id_width_p`, default `bsg_manycore_reg_id_width_gp` (5): register id width; must be 5.
- `clk_i`  in  1  core clock.
- `reset_n_i`  in  1  reset, asynchronous, active-low.
- `v_i`  in  1  response valid from network endpoint.
- `resp_i`  in  `$bits(remote_load_resp_s)`  fields: `float_wb`, `reg_id`, `is_unsigned_op`, `is_byte_op`, `is_hex_op`, `part_sel`, `data`.
- `ready_o`  out  1  block can accept a response this cycle.
- `int_v_o`  out  1  integer writeback request.
- `int_rd_o`  out  5  integer destination register.
- `int_data_o`  out  32  formatted integer data.
- `int_yumi_i`  in  1  integer writeback accepted (dequeue).
- `float_v_o`  out  1  FP writeback request.
- `float_rd_o`  out  5  FP destination register.
- `float_data_o`  out  32  raw FP data.
- `float_yumi_i`  in  1  FP writeback accepted (dequeue).
- `count_o`  out  `$clog2(els_p+1)`  occupied entries.

## Operation
- **Storage.** Circular FIFO of `els_p` raw `remote_load_resp_s` entries.
  - Write and read pointers are `$clog2(els_p)` bits and wrap naturally.
  - Count register is `$clog2(els_p+1)` bits.
- **Enqueue.** When `v_i & ready_o`, the entry is written at the write pointer.
  - `ready_o = (count < els_p)`, registered-state only; there is no full-bypass.
  - A full FIFO does not accept a response even when a dequeue happens in the same cycle.
- **Head formatting** is combinational from the head entry; `d = data`, `p = part_sel`.
  - Byte: `b = d[8*p +: 8]`. Result is `{24{~unsigned & b[7]}, b}`.
  - Hex: `h = d[16*p[1] +: 16]`; `p[0]` is ignored. Result is `{16{~unsigned & h[15]}, h}`.
  - Otherwise: `d` unchanged.
  - Byte takes priority if `is_byte_op` and `is_hex_op` are both set.
- **Routing.**
  - If head `float_wb=1`: `float_v_o=1`, `float_rd_o=reg_id`, `float_data_o=d` unformatted; byte, hex and unsigned bits are ignored.
  - If head `float_wb=0` and `reg_id≠0`: `int_v_o=1`, `int_rd_o=reg_id`, `int_data_o` = formatted result.
  - If head `float_wb=0` and `reg_id=0`: a write to x0. The entry is discarded internally in one cycle with no output valid and no yumi required.
- **Output exclusivity.** At most one of `int_v_o` / `float_v_o` is high in any cycle.
  - When a valid is low, its rd and data outputs are driven 0.
- **Dequeue.**
  - The head is popped on `int_yumi_i & int_v_o`, on `float_yumi_i & float_v_o`, or on an x0 discard.
  - A yumi while the matching valid is low is a protocol violation; assert it in simulation and ignore it in RTL.
- **Simultaneous events.** Enqueue and dequeue in the same cycle (only possible when not full): count is unchanged and both pointers advance.
- **Reset.** Asynchronous assertion of `reset_n_i=0`:
  - Pointers and count clear to 0; FIFO contents are don't-care.
  - `int_v_o=0`, `float_v_o=0`, all rd and data outputs 0.
  - `ready_o=1`, `count_o=0`.
  - A reset mid-operation drops all buffered responses; no writeback is issued for them.

## Timing
- **Latency.** A response accepted at cycle N is presented at cycle N+1 at the earliest; there is no input-to-output combinational path.
- **Throughput.** One response per cycle in steady state when the arbiter yumis every cycle.
- **Combinational paths.**
  - `ready_o` depends only on registered count.
  - Output valid, rd and data depend only on registered state.
  - Yumi inputs affect only next-state logic.
- **Arbiter stall.** Holding yumi low keeps the head and its outputs stable.
  - Upstream may fill the remaining `els_p-1` entries; `ready_o` then falls.
- **x0 discard.** Costs one cycle of head occupancy.

## Test plan
- **Byte/hex extraction.** Enqueue int responses with `reg_id=3`, `data=32'h80FF7F01`, and back-to-back yumi:
  - byte signed, `part_sel=3` → `int_data_o=32'hFFFFFF80`.
  - byte unsigned, `part_sel=2` → `32'h000000FF`.
  - hex signed, `part_sel=2` → `32'hFFFF80FF`.
  - hex unsigned, `part_sel=0` → `32'h00007F01`.
- **Float routing.** Enqueue `float_wb=1`, `reg_id=7`, `is_byte_op=1`, `data=32'h3F800000` → `float_v_o=1`, `float_rd_o=7`, `float_data_o=32'h3F800000`, `int_v_o=0`.
- **Full and backpressure.** Default `els_p=2`, yumi held low, three consecutive `v_i`:
  - The first two are accepted; `ready_o=0` on the third cycle; `count_o=2`.
  - Yumi once → `ready_o=1` next cycle.
  - Entries drain in order.
- **x0 discard.** Enqueue int `reg_id=0`, then int `reg_id=5`:
  - `int_v_o` is never high for the first entry.
  - The second entry is presented one cycle later.
- **Simultaneous push/pop.** Count=1 with yumi and `v_i` in the same cycle → `count_o` stays 1 and the pointers wrap correctly over 8 iterations.
- **Mid-operation reset.** Pulse `reset_n_i` low asynchronously with 2 entries buffered:
  - All outputs are at reset values immediately, `count_o=0`, `ready_o=1`.
  - No stale writeback appears after release.
